// File: rtl/mash_cic_decimator_if.sv
// Sample/result bundle for the MASH 1-1-1 CIC decimator.
// The master drives the fractional stream and the slave (the filter) returns decimated results.
interface mash_cic_decimator_if #(
    parameter int LOG2_R = 3
);
    localparam int ACC_W = 4 + 3 * LOG2_R;

    logic signed [3:0]       in_f;
    logic                    in_valid;
    logic signed [ACC_W-1:0] dout;
    logic                    dout_valid;
    logic                    range_err;

    modport master (
        output in_f,
        output in_valid,
        input  dout,
        input  dout_valid,
        input  range_err
    );

    modport slave (
        input  in_f,
        input  in_valid,
        output dout,
        output dout_valid,
        output range_err
    );
endinterface

// File: rtl/mash_cic_decimator.sv
// Sinc^3 CIC decimator (ratio 2**LOG2_R) that reconstructs the mean of a MASH 1-1-1 stream.
// Optional sticky illegal-input flag is built when MASH_RANGE_CHK_EN is defined.
module mash_cic_decimator #(
    parameter int LOG2_R = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    mash_cic_decimator_if.slave   s_if
);
    localparam int ACC_W = 4 + 3 * LOG2_R;
    localparam logic [LOG2_R-1:0] CNT_MAX = '1;

    logic signed [ACC_W-1:0] r_i1, r_i2, r_i3;
    logic signed [ACC_W-1:0] r_d1, r_d2, r_d3;
    logic signed [ACC_W-1:0] r_dout;
    logic [LOG2_R-1:0]       r_cnt;
    logic                    r_dec_stb;
    logic [1:0]              r_warm;
    logic                    r_dout_valid;

    logic signed [ACC_W-1:0] w_in_sext;
    logic signed [ACC_W-1:0] w_i1_nxt, w_i2_nxt, w_i3_nxt;
    logic signed [ACC_W-1:0] w_c1, w_c2, w_c3;

    // Integrators wrap modulo 2**ACC_W on purpose; the combs cancel the wrap.
    assign w_in_sext = {{(ACC_W-4){s_if.in_f[3]}}, s_if.in_f};
    assign w_i1_nxt  = r_i1 + w_in_sext;
    assign w_i2_nxt  = r_i2 + w_i1_nxt;
    assign w_i3_nxt  = r_i3 + w_i2_nxt;

    assign w_c1 = r_i3 - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    // Integrator cascade, decimation counter and registered decimation strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_i3      <= '0;
            r_cnt     <= '0;
            r_dec_stb <= 1'b0;
        end else if (clr) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_i3      <= '0;
            r_cnt     <= '0;
            r_dec_stb <= 1'b0;
        end else if (s_if.in_valid) begin
            r_i1      <= w_i1_nxt;
            r_i2      <= w_i2_nxt;
            r_i3      <= w_i3_nxt;
            r_cnt     <= r_cnt + LOG2_R'(1);
            r_dec_stb <= (r_cnt == CNT_MAX);
        end else begin
            r_dec_stb <= 1'b0;
        end
    end

    // Comb chain and output register; the first two results only prime the comb delays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1         <= '0;
            r_d2         <= '0;
            r_d3         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_warm       <= 2'd0;
        end else if (clr) begin
            r_d1         <= '0;
            r_d2         <= '0;
            r_d3         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_warm       <= 2'd0;
        end else if (r_dec_stb) begin
            r_d1 <= r_i3;
            r_d2 <= w_c1;
            r_d3 <= w_c2;
            if (r_warm == 2'd2) begin
                r_dout       <= w_c3;
                r_dout_valid <= 1'b1;
            end else begin
                r_warm       <= r_warm + 2'd1;
                r_dout_valid <= 1'b0;
            end
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign s_if.dout       = r_dout;
    assign s_if.dout_valid = r_dout_valid;

`ifdef MASH_RANGE_CHK_EN
    logic r_range_err;

    // Legal shaper words are -3..+4; anything from -8 to -4 is an upstream fault.
    function automatic logic in_illegal(input logic signed [3:0] f);
        return (f < -4'sd3);
    endfunction

    // Sticky range flag, cleared only by reset or soft clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (clr) begin
            r_range_err <= 1'b0;
        end else if (s_if.in_valid && in_illegal(s_if.in_f)) begin
            r_range_err <= 1'b1;
        end else begin
            r_range_err <= r_range_err;
        end
    end

    assign s_if.range_err = r_range_err;
`else
    assign s_if.range_err = 1'b0;
`endif
endmodule

// File: tb/tb_mash_cic_decimator.sv
// Directed bench for mash_cic_decimator at LOG2_R=3 (R=8, DC gain 512).
module tb_mash_cic_decimator;
    localparam int LOG2_R = 3;
    localparam int ACC_W  = 4 + 3 * LOG2_R;

    logic clk;
    logic rst_n;
    logic clr;
    int   cyc;
    int   n_checks;
    int   n_fails;

    logic signed [ACC_W-1:0] res_val [0:255];
    int                      res_cyc [0:255];
    int                      nres;

    mash_cic_decimator_if #(.LOG2_R(LOG2_R)) u_if ();

    mash_cic_decimator #(.LOG2_R(LOG2_R)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .s_if  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every flagged result with the cycle it became visible.
    always @(negedge clk) begin
        if (u_if.dout_valid === 1'b1 && nres < 256) begin
            res_val[nres] <= u_if.dout;
            res_cyc[nres] <= cyc;
            nres          <= nres + 1;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic signed [3:0] f, input logic v, input logic c);
        u_if.in_f     = f;
        u_if.in_valid = v;
        clr           = c;
        @(posedge clk);
        #1;
    endtask

    // Two-phase stream: even cycles use (f0,v0), odd cycles (f1,v1); then idle to flush.
    task automatic stream(input logic signed [3:0] f0, input logic signed [3:0] f1,
                          input logic v0, input logic v1, input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) drive(f0, v0, 1'b0);
            else            drive(f1, v1, 1'b0);
        end
        for (int i = 0; i < 4; i++) drive(4'sd0, 1'b0, 1'b0);
    endtask

    task automatic soft_clear();
        drive(4'sd0, 1'b0, 1'b1);
        drive(4'sd0, 1'b0, 1'b0);
    endtask

    int base;
    int start;
    logic exp_rerr;

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        nres          = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        clr           = 1'b0;
        u_if.in_f     = 4'sd0;
        u_if.in_valid = 1'b0;
`ifdef MASH_RANGE_CHK_EN
        exp_rerr = 1'b1;
`else
        exp_rerr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", u_if.dout, 0);
        check("reset_valid", u_if.dout_valid, 0);
        check("reset_rerr", u_if.range_err, 0);
        rst_n = 1'b1;
        drive(4'sd0, 1'b0, 1'b0);

        // 1: constant +1 from reset
        base  = nres;
        start = cyc;
        stream(4'sd1, 4'sd1, 1'b1, 1'b1, 48);
        check("t1_count", nres - base, 4);
        check("t1_latency", res_cyc[base] - start, 25);
        check("t1_first", res_val[base], 512);
        check("t1_spacing", res_cyc[base+1] - res_cyc[base], 8);
        check("t1_last", res_val[base+3], 512);
        check("t1_hold", u_if.dout, 512);
        check("t1_strobe_low", u_if.dout_valid, 0);

        // 2: constant extremes
        soft_clear();
        check("clr_dout", u_if.dout, 0);
        base = nres;
        stream(-4'sd3, -4'sd3, 1'b1, 1'b1, 40);
        check("t2_neg_count", nres - base, 3);
        check("t2_neg_first", res_val[base], -1536);
        check("t2_neg_last", res_val[base+2], -1536);
        soft_clear();
        base = nres;
        stream(4'sd4, 4'sd4, 1'b1, 1'b1, 40);
        check("t2_pos_first", res_val[base], 2048);
        check("t2_pos_last", res_val[base+2], 2048);

        // 3: alternating patterns with mean 1/2
        soft_clear();
        base = nres;
        stream(4'sd1, 4'sd0, 1'b1, 1'b1, 40);
        check("t3_10_first", res_val[base], 256);
        check("t3_10_last", res_val[base+2], 256);
        soft_clear();
        base = nres;
        stream(4'sd4, -4'sd3, 1'b1, 1'b1, 40);
        check("t3_43_first", res_val[base], 256);
        check("t3_43_last", res_val[base+2], 256);
        check("t3_rerr", u_if.range_err, 0);

        // 4: gapped stream stretches time only
        soft_clear();
        base  = nres;
        start = cyc;
        stream(4'sd2, 4'sd2, 1'b1, 1'b0, 96);
        check("t4_count", nres - base, 4);
        check("t4_latency", res_cyc[base] - start, 48);
        check("t4_first", res_val[base], 1024);
        check("t4_spacing", res_cyc[base+1] - res_cyc[base], 16);
        check("t4_last", res_val[base+3], 1024);

        // 5: async reset mid-frame, then clr with a live sample
        for (int i = 0; i < 13; i++) drive(4'sd1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_dout", u_if.dout, 0);
        check("t5_async_valid", u_if.dout_valid, 0);
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'sd0, 1'b0, 1'b0);
        drive(4'sd4, 1'b1, 1'b1);
        check("t5_clr_dout", u_if.dout, 0);
        check("t5_clr_valid", u_if.dout_valid, 0);
        base  = nres;
        start = cyc;
        for (int i = 0; i < 16; i++) drive(4'sd1, 1'b1, 1'b0);
        check("t5_warmup_quiet", nres - base, 0);
        stream(4'sd1, 4'sd1, 1'b1, 1'b1, 8);
        check("t5_count", nres - base, 1);
        check("t5_latency", res_cyc[base] - start, 25);
        check("t5_value", res_val[base], 512);

        // 6: range flag
        drive(-4'sd4, 1'b1, 1'b0);
        check("t6_set", u_if.range_err, exp_rerr);
        for (int i = 0; i < 5; i++) drive(4'sd0, 1'b1, 1'b0);
        check("t6_sticky", u_if.range_err, exp_rerr);
        drive(4'sd0, 1'b0, 1'b1);
        check("t6_cleared", u_if.range_err, 0);
        drive(-4'sd8, 1'b0, 1'b0);
        check("t6_invalid_ignored", u_if.range_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
